// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode/funct constants, descriptor kinds and halt-word layout
// shared by the instruction encoder and the core's decoder.  Rev 1.0
`default_nettype none
package mips_isa_pkg;

  typedef enum logic [3:0] {
    K_ADDU  = 4'd0,
    K_SUBU  = 4'd1,
    K_AND   = 4'd2,
    K_OR    = 4'd3,
    K_SLTU  = 4'd4,
    K_LW    = 4'd5,
    K_SW    = 4'd6,
    K_BEQ   = 4'd7,
    K_ADDIU = 4'd8,
    K_J     = 4'd9,
    K_LUI   = 4'd10,
    K_ORI   = 4'd11,
    K_BLTZ  = 4'd12
  } kind_e;

  localparam logic [5:0] c_OP_SPECIAL = 6'h00;
  localparam logic [5:0] c_OP_REGIMM  = 6'h01;
  localparam logic [5:0] c_OP_J       = 6'h02;
  localparam logic [5:0] c_OP_BEQ     = 6'h04;
  localparam logic [5:0] c_OP_ADDIU   = 6'h09;
  localparam logic [5:0] c_OP_ORI     = 6'h0D;
  localparam logic [5:0] c_OP_LUI     = 6'h0F;
  localparam logic [5:0] c_OP_LW      = 6'h23;
  localparam logic [5:0] c_OP_SW      = 6'h2B;

  localparam logic [5:0] c_FN_ADDU = 6'h21;
  localparam logic [5:0] c_FN_SUBU = 6'h23;
  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_OR   = 6'h25;
  localparam logic [5:0] c_FN_SLTU = 6'h2B;

  // A halt is an unconditional jump whose target is its own word address.
  function automatic logic [31:0] halt_word(input logic [25:0] target);
    return {c_OP_J, target};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_stream_encoder_if.sv
// instr_stream_encoder_if: descriptor handshake between host and encoder.  Rev 1.0
`default_nettype none
interface instr_stream_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        seal;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, seal,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, seal,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational kind + fields -> 32-bit MIPS word, with valid flag.  Rev 1.0
`default_nettype none
module instr_field_packer
  import mips_isa_pkg::*;
(
  input  wire logic [3:0]  kind_i,
  input  wire logic [4:0]  rs_i,
  input  wire logic [4:0]  rt_i,
  input  wire logic [4:0]  rd_i,
  input  wire logic [15:0] imm_i,
  input  wire logic [25:0] target_i,
  output logic [31:0]      word_o,
  output logic             valid_o
);

  always_comb begin
    word_o  = 32'd0;
    valid_o = 1'b1;
    case (kind_i)
      K_ADDU:  word_o = {c_OP_SPECIAL, rs_i, rt_i, rd_i, 5'd0, c_FN_ADDU};
      K_SUBU:  word_o = {c_OP_SPECIAL, rs_i, rt_i, rd_i, 5'd0, c_FN_SUBU};
      K_AND:   word_o = {c_OP_SPECIAL, rs_i, rt_i, rd_i, 5'd0, c_FN_AND};
      K_OR:    word_o = {c_OP_SPECIAL, rs_i, rt_i, rd_i, 5'd0, c_FN_OR};
      K_SLTU:  word_o = {c_OP_SPECIAL, rs_i, rt_i, rd_i, 5'd0, c_FN_SLTU};
      K_LW:    word_o = {c_OP_LW,    rs_i, rt_i, imm_i};
      K_SW:    word_o = {c_OP_SW,    rs_i, rt_i, imm_i};
      K_BEQ:   word_o = {c_OP_BEQ,   rs_i, rt_i, imm_i};
      K_ADDIU: word_o = {c_OP_ADDIU, rs_i, rt_i, imm_i};
      K_ORI:   word_o = {c_OP_ORI,   rs_i, rt_i, imm_i};
      // LUI has no source register and BLTZ uses rt as a sub-opcode (0).
      K_LUI:   word_o = {c_OP_LUI,    5'd0, rt_i, imm_i};
      K_BLTZ:  word_o = {c_OP_REGIMM, rs_i, 5'd0, imm_i};
      K_J:     word_o = {c_OP_J, target_i};
      default: valid_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: packs descriptors into MIPS words and streams them into
// consecutive instruction-memory words, optionally sealing with a jump-to-self.  Rev 1.0
`default_nettype none
module instr_stream_encoder
  import mips_isa_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int BASE_WORD  = 0,
  parameter int AW         = $clog2(IMEM_DEPTH)
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                clear,
  instr_stream_encoder_if.slave    in_bus,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [31:0]              wr_data,
  output logic [AW:0]              count,
  output logic                     err,
  output logic                     done
);

  localparam logic [1:0] S_ACCEPT = 2'd0;
  localparam logic [1:0] S_SEAL   = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [AW:0]  c_FULL = (AW+1)'(IMEM_DEPTH);
  localparam logic [25:0]  c_BASE = 26'(BASE_WORD);

  logic [1:0]    state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;

  logic [31:0]   w_word;
  logic          w_kind_ok;
  logic          w_xfer;
  logic [25:0]   w_halt_tgt;

  instr_field_packer u_packer (
    .kind_i   (in_bus.in_kind),
    .rs_i     (in_bus.in_rs),
    .rt_i     (in_bus.in_rt),
    .rd_i     (in_bus.in_rd),
    .imm_i    (in_bus.in_imm),
    .target_i (in_bus.in_target),
    .word_o   (w_word),
    .valid_o  (w_kind_ok)
  );

  assign in_bus.in_ready = (state_q == S_ACCEPT) && !clear && (count_q < c_FULL);
  assign w_xfer          = in_bus.in_valid && in_bus.in_ready;
  assign w_halt_tgt      = c_BASE + 26'(count_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (clear) begin
      state_d   = S_ACCEPT;
      count_d   = '0;
      err_d     = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (w_xfer) begin
            if (w_kind_ok) begin
              wr_en_d   = 1'b1;
              wr_addr_d = count_q[AW-1:0];
              wr_data_d = w_word;
              count_d   = count_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          // Seal decision uses the count after any same-cycle instruction write.
          if (in_bus.seal) begin
            if (count_d < c_FULL) begin
              state_d = S_SEAL;
            end else begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        S_SEAL: begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q[AW-1:0];
          wr_data_d = halt_word(w_halt_tgt);
          count_d   = count_q + 1'b1;
          state_d   = S_DONE;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_ACCEPT;
      count_q   <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;
  assign err     = err_q;
  assign done    = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_encoder.sv
// tb_instr_stream_encoder: randomized + directed scoreboard bench for instr_stream_encoder.  Rev 1.0
`default_nettype none
module tb_instr_stream_encoder;

  localparam int DEPTH = 4;
  localparam int BASE  = 0;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   count;
  logic          err;
  logic          done;

  instr_stream_encoder_if bus ();

  instr_stream_encoder #(.IMEM_DEPTH(DEPTH), .BASE_WORD(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .in_bus  (bus.slave),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .count   (count),
    .err     (err),
    .done    (done)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t sb[$];

  // Reference state: words written, sticky error, sealed, halt word owed next cycle.
  int  m_count   = 0;
  bit  m_err     = 0;
  bit  m_done    = 0;
  bit  m_sealing = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint ref_word(input int kind, input longint rs, input longint rt,
                                      input longint rd, input longint imm, input longint tgt);
    longint op6 = 64'd67108864;  // 2**26
    longint s21 = 64'd2097152;
    longint s16 = 64'd65536;
    longint s11 = 64'd2048;
    case (kind)
      0:  return rs*s21 + rt*s16 + rd*s11 + 'h21;
      1:  return rs*s21 + rt*s16 + rd*s11 + 'h23;
      2:  return rs*s21 + rt*s16 + rd*s11 + 'h24;
      3:  return rs*s21 + rt*s16 + rd*s11 + 'h25;
      4:  return rs*s21 + rt*s16 + rd*s11 + 'h2B;
      5:  return 'h23*op6 + rs*s21 + rt*s16 + imm;
      6:  return 'h2B*op6 + rs*s21 + rt*s16 + imm;
      7:  return 'h04*op6 + rs*s21 + rt*s16 + imm;
      8:  return 'h09*op6 + rs*s21 + rt*s16 + imm;
      9:  return 2*op6 + tgt;
      10: return 'h0F*op6 + rt*s16 + imm;
      11: return 'h0D*op6 + rs*s21 + rt*s16 + imm;
      12: return 'h01*op6 + rs*s21 + imm;
      default: return -1;
    endcase
  endfunction

  // Monitor: every observed write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%08h, expected none at %0t",
                   wr_addr, wr_data, $time);
        end else begin
          e = sb.pop_front();
          check("wr_addr", longint'(wr_addr), longint'(e.addr));
          check("wr_data", longint'(wr_data), longint'(e.data));
        end
      end
    end
  end

  task automatic step(input bit rst, input bit clr, input bit v, input int kind,
                      input int rs, input int rt, input int rd, input int imm,
                      input int tgt, input bit sl);
    bit ready;
    bit ok_kind;
    @(posedge clk);
    #1;
    check("count", longint'(count), m_count);
    check("err",   longint'(err),   longint'(m_err));
    check("done",  longint'(done),  longint'(m_done));
    #1;
    reset         = rst;
    clear         = clr;
    bus.in_valid  = v;
    bus.in_kind   = 4'(kind);
    bus.in_rs     = 5'(rs);
    bus.in_rt     = 5'(rt);
    bus.in_rd     = 5'(rd);
    bus.in_imm    = 16'(imm);
    bus.in_target = 26'(tgt);
    bus.seal      = sl;
    #1;
    ready = !clr && !m_done && !m_sealing && (m_count < DEPTH);
    if (!rst) check("in_ready", longint'(bus.in_ready), longint'(ready));
    if (rst || clr) begin
      m_count = 0; m_err = 0; m_done = 0; m_sealing = 0;
    end else if (m_sealing) begin
      sb.push_back('{addr: m_count, data: 32'(ref_word(9, 0, 0, 0, 0, (BASE + m_count) % (1 << 26)))});
      m_count++;
      m_sealing = 0;
      m_done    = 1;
    end else if (!m_done) begin
      ok_kind = kind < 13;
      if (v && ready) begin
        if (ok_kind) begin
          sb.push_back('{addr: m_count, data: 32'(ref_word(kind, rs, rt, rd, imm, tgt))});
          m_count++;
        end else begin
          m_err = 1;
        end
      end
      if (sl) begin
        if (m_count < DEPTH) m_sealing = 1;
        else begin m_err = 1; m_done = 1; end
      end
    end
  endtask

  task automatic idle(input bit clr = 0);
    step(0, clr, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic put(input int kind, input int rs, input int rt, input int rd,
                     input int imm, input bit sl = 0);
    step(0, 0, 1, kind, rs, rt, rd, imm, 0, sl);
  endtask

  initial begin
    reset = 1; clear = 0;
    bus.in_valid = 0; bus.in_kind = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_rd = 0;
    bus.in_imm = 0; bus.in_target = 0; bus.seal = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    check("rst_wr_en",   longint'(wr_en),   0);
    check("rst_wr_addr", longint'(wr_addr), 0);
    check("rst_wr_data", longint'(wr_data), 0);

    // Back-to-back ADDU / LW.
    put(0, 1, 2, 3, 0);
    put(5, 29, 8, 0, 4);
    idle();
    // Clear with in_valid high: nothing accepted that cycle.
    step(0, 1, 1, 8, 1, 1, 1, 1, 0, 0);
    // BEQ / LUI / BLTZ with forced-zero fields, then seal -> halt at 3.
    put(7, 1, 2, 0, 'hFFFF);
    put(10, 7, 5, 0, 'h1234);
    put(12, 4, 9, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(); idle();
    put(0, 1, 1, 1, 0);
    // Invalid kind then ADDIU at the unchanged address.
    idle(1);
    put(14, 3, 3, 3, 3);
    put(8, 0, 2, 0, 7);
    idle();
    // Fill to DEPTH, further input refused, seal while full -> err, no write.
    idle(1);
    put(3, 1, 2, 3, 0); put(4, 4, 5, 6, 0); put(6, 7, 8, 0, 9); put(11, 1, 2, 0, 'hBEEF);
    put(1, 9, 9, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    // Seal alongside a transfer: instruction first, halt at next address.
    idle(1);
    put(2, 1, 2, 3, 0); put(2, 4, 5, 6, 0, 1);
    idle(); idle();
    // Seal alongside the transfer that fills memory -> full case.
    idle(1);
    put(0, 1, 1, 1, 0); put(0, 2, 2, 2, 0); put(0, 3, 3, 3, 0); put(9, 0, 0, 0, 0, 1);
    idle();
    // J kind, then reset while the halt word is pending.
    idle(1);
    step(0, 0, 1, 9, 0, 0, 0, 0, 'h3ABCDEF, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();

    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 99);
      step(r < 1, (r >= 1) && (r < 7), $urandom_range(0, 9) < 7, $urandom_range(0, 15),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 65535), $urandom_range(0, 67108863), $urandom_range(0, 24) == 0);
    end
    idle(); idle(); idle();
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Sequential MIPS instruction encoder, the inverse of the core's instruction decoder: it accepts field-level instruction descriptors over a valid/ready handshake, packs them into 32-bit instruction words, and writes them to consecutive instruction-memory words. It sits between the test/boot host and the instruction memory's write port. It can also terminate a program by appending a jump-to-self halt word.

## Interface
- IMEM_DEPTH, 64: instruction-memory depth in words; AW = $clog2(IMEM_DEPTH).
- BASE_WORD, 0: word address of memory entry 0, used for the seal jump target.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous restart: count, err, state cleared; has priority over all inputs except reset.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  encoder can accept; combinational.
- in_kind  in  4  0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLTU, 5 LW, 6 SW, 7 BEQ, 8 ADDIU, 9 J, 10 LUI, 11 ORI, 12 BLTZ, 13–15 invalid.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  I-type immediate.
- in_target  in  26  J-type target.
- seal  in  1  one-cycle pulse: append halt word, then stop.
- wr_en  out  1  instruction-memory write strobe (registered).
- wr_addr  out  AW  word index (registered).
- wr_data  out  32  encoded word (registered).
- count  out  AW+1  words written or committed so far.
- err  out  1  sticky: invalid kind or seal while full.
- done  out  1  program sealed; no further acceptance.

## Operation
- Encoding:
  - R-type {000000, rs, rt, rd, 00000, funct}, funct 21/23/24/25/2B (hex) for ADDU/SUBU/AND/OR/SLTU.
  - I-type {op, rs, rt, imm}, op LW 23, SW 2B, BEQ 04, ADDIU 09, ORI 0D.
  - LUI op 0F with rs forced 0.
  - BLTZ op 01 with rt forced 0.
  - J {000010, in_target}.
- States:
  - ACCEPT: in_ready = ~clear & (count < IMEM_DEPTH).
  - SEAL: in_ready 0; writes halt word {000010, BASE_WORD+count truncated to 26 bits} at count, count+1, then → DONE.
  - DONE: in_ready 0, done 1; left only by clear or reset.
- Handshake: transfer when in_valid & in_ready. A valid kind registers wr_data/wr_addr=count, sets wr_en, and increments count. An invalid kind sets err, writes nothing, leaves count unchanged, and is still consumed.
- Seal while in ACCEPT: → SEAL if count < IMEM_DEPTH, else set err and → DONE with no write. If seal and a transfer occur in the same cycle, the instruction is written first and the halt word follows at the next address. If count+1 then equals IMEM_DEPTH, the seal is treated as the full case: err set, no halt word written. Seal in SEAL or DONE is ignored.
- Full: count == IMEM_DEPTH; in_ready stays low and the count does not wrap.

## Timing
- Latency 1: a transfer at edge N produces wr_en=1 in cycle N..N+1, so it is visible the cycle after acceptance; back-to-back transfers sustain 1 word/cycle.
- count updates at the same edge that launches the write.
- Reset and clear values: state ACCEPT, count 0, wr_en 0, wr_addr 0, wr_data 0, err 0, done 0; in_ready is 1 in the first cycle after reset (if clear is low).
- Clear: a write already registered completes in the current cycle. No transfer occurs in a cycle with clear high. A pending seal is cancelled.
- Reset mid-SEAL: the halt word is never written.

## Structure
- Shared package mips_isa_pkg holds the kind enum, opcode/funct constants, and halt-word layout; the decoder uses the same opcode/funct constants.
- Combinational sub-module instr_field_packer (kind + fields → word, valid flag); the top level holds the FSM, counter, and output registers.

## Test plan
- ADDU rs=1 rt=2 rd=3, then LW rs=29 rt=8 imm=4 back-to-back → wr_data 0x00221821 @0, then 0x8FA80004 @1 on consecutive cycles; count 2.
- BEQ rs=1 rt=2 imm=FFFF; LUI rs=7 rt=5 imm=1234; BLTZ rs=4 rt=9 imm=3 → 0x1022FFFF, 0x3C051234, 0x04800003 (forced zero fields).
- Three words, then seal (BASE_WORD 0) → 0x08000003 written @3; done=1; in_ready 0.
- Kind 14 → no write, err=1, count unchanged; next ADDIU rs=0 rt=2 imm=7 → 0x24020007 at unchanged address.
- IMEM_DEPTH=4: fill 4 words → in_ready 0; seal → err=1, done=1, no write.
- Clear asserted with in_valid high mid-stream → no acceptance that cycle; next transfer written @0, err/done cleared.
